// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Bytes per instruction: opcode, operand1, operand2.
    localparam int INSTR_BYTES = 3;

    // Opcode that parks the fetcher when the halt option is built in.
    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    // Default program counter after reset.
    localparam int RESET_PC_DEFAULT = 0;

    // Fetch sequencer states. HALT is reachable only with FETCH_HALT_EN.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_OP   = 3'd1,
        F_A1   = 3'd2,
        F_A2   = 3'd3,
        F_DONE = 3'd4,
        HOLD   = 3'd5,
        HALT   = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and reads 3-byte instructions
// from a RAM with a one-cycle read latency into the IR. Each instruction is
// then offered to the control unit with a valid/ready handshake.
// pc_load redirects the fetch stream and aborts any fetch in progress.
// Optional macro FETCH_HALT_EN adds a HALT state and a 'halted' output.
// A transferred instruction with opcode 8'hFF enters HALT. Only rst or
// pc_load leaves HALT.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_operand1,
    output logic [DATA_W-1:0] ir_operand2,
    output logic              ir_valid,
    input  logic              ex_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic [ADDR_W-1:0] pc,
`ifdef FETCH_HALT_EN
    output logic              halted,
`endif
    output logic              busy
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              cap_op;
    logic              cap_a1;
    logic              cap_a2;
    logic              vld_set;
    logic              vld_clr;
    logic              xfer;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, PC update, IR capture strobes and the RAM read strobe.
    // A redirect overrides all of these, except in IDLE with fetch_en low.
    // The redirect does not suppress a read strobe in the same cycle. That
    // read returns while the sequencer is back in F_OP, and no capture
    // strobe is active there, so the returned byte is discarded.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cap_op    = 1'b0;
        cap_a1    = 1'b0;
        cap_a2    = 1'b0;
        vld_set   = 1'b0;
        vld_clr   = 1'b0;
        ram_rd_en = 1'b0;
        xfer      = ir_valid && ex_ready;

        case (state)
            IDLE: begin
                if (fetch_en) begin
                    state_nxt = F_OP;
                end
            end
            F_OP: begin
                ram_rd_en = 1'b1;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = F_A1;
            end
            F_A1: begin
                ram_rd_en = 1'b1;
                cap_op    = 1'b1;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = F_A2;
            end
            F_A2: begin
                ram_rd_en = 1'b1;
                cap_a1    = 1'b1;
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = F_DONE;
            end
            F_DONE: begin
                cap_a2    = 1'b1;
                vld_set   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (xfer) begin
                    vld_clr = 1'b1;
`ifdef FETCH_HALT_EN
                    if (ir_opcode == DATA_W'(HALT_OPCODE)) begin
                        state_nxt = HALT;
                    end else
`endif
                    if (fetch_en) begin
                        state_nxt = F_OP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                state_nxt = HALT;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (pc_load) begin
            pc_nxt = pc_load_addr;
            if (!(state == IDLE && !fetch_en)) begin
                state_nxt = F_OP;
                cap_op    = 1'b0;
                cap_a1    = 1'b0;
                cap_a2    = 1'b0;
                vld_set   = 1'b0;
                vld_clr   = 1'b1;
            end
        end
    end

    // Address the RAM only while a read is being issued.
    assign ram_addr = ram_rd_en ? pc : '0;
    assign busy     = (state != IDLE);

`ifdef FETCH_HALT_EN
    assign halted = (state == HALT);
`endif

    // PC register: wraps modulo 2^ADDR_W with no overflow indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // IR capture. Each byte is taken in the cycle after its read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_opcode   <= '0;
            ir_operand1 <= '0;
            ir_operand2 <= '0;
        end else begin
            if (cap_op) ir_opcode   <= ram_rd_data;
            if (cap_a1) ir_operand1 <= ram_rd_data;
            if (cap_a2) ir_operand2 <= ram_rd_data;
        end
    end

    // ir_valid: set when the last byte lands; cleared on transfer or redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_valid <= 1'b0;
        end else if (vld_clr) begin
            ir_valid <= 1'b0;
        end else if (vld_set) begin
            ir_valid <= 1'b1;
        end
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequencer for the instruction-fetch path: owns the PC.
- Drives the RAM read port byte by byte to assemble 3-byte instructions (opcode, operand1, operand2) into the IR.
- Presents each instruction to the control unit with a valid/ready handshake.
- Sits between RandomAcessMemory and the control unit; accepts PC redirects (jumps) from the control unit.

Parameters:
- ADDR_W, 8, RAM address and PC width.
- DATA_W, 8, RAM data and IR field width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- fetch_en  in  1  run enable; a new fetch starts only when high.
- ram_rd_en  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  RAM read data; valid exactly 1 cycle after a ram_rd_en cycle.
- ir_opcode  out  DATA_W  instruction byte 0.
- ir_operand1  out  DATA_W  instruction byte 1.
- ir_operand2  out  DATA_W  instruction byte 2.
- ir_valid  out  1  IR holds a complete instruction.
- ex_ready  in  1  control unit accepts the IR.
- pc_load  in  1  redirect request.
- pc_load_addr  in  ADDR_W  redirect target.
- pc  out  ADDR_W  address of the next byte to fetch.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pc=RESET_PC.
  - ir_* = 0; ir_valid=0; ram_rd_en=0; ram_addr=0.
- States: IDLE, F_OP, F_A1, F_A2, F_DONE, HOLD.
- IDLE: if fetch_en, go to F_OP.
- F_OP: ram_rd_en=1, ram_addr=pc; pc<=pc+1.
- F_A1: ram_rd_en=1, ram_addr=pc; ir_opcode<=ram_rd_data; pc<=pc+1.
- F_A2: ram_rd_en=1, ram_addr=pc; ir_operand1<=ram_rd_data; pc<=pc+1.
- F_DONE: ir_operand2<=ram_rd_data; ir_valid<=1; go to HOLD.
- HOLD:
  - IR and ir_valid remain stable until ir_valid&&ex_ready.
  - On transfer: ir_valid<=0; next state is F_OP if fetch_en, else IDLE.
- Latency: ir_valid rises 4 cycles after entering F_OP. Back-to-back throughput is 1 instruction per 5 cycles with ex_ready tied high.
- ram_rd_en is low in IDLE, F_DONE and HOLD.
- Arithmetic and wrap:
  - PC arithmetic is modulo 2^ADDR_W: 8'hFF+1=8'h00, no flag.
  - An instruction may straddle the wrap: bytes read from FF, 00, 01.
- Redirect:
  - pc_load has priority over all fetch activity in any state except IDLE-with-fetch_en-low.
  - Effect: pc<=pc_load_addr; any in-flight fetch is aborted; ir_valid<=0; next state F_OP.
  - Data returned for an aborted read is discarded.
  - pc_load while in IDLE with fetch_en low: pc is updated, state stays IDLE.
- pc_load and transfer in the same cycle: the transfer completes (the consumer got the IR), and the redirect target is used for the next fetch.
- fetch_en dropped mid-fetch: the current instruction completes to HOLD; no new fetch is started after transfer.
- Reset mid-fetch: immediate return to reset values; the partial IR is lost.

Optional Feature:
- Macro: FETCH_HALT_EN.
- With the macro defined:
  - Adds output halted (1 bit, reset 0).
  - When a transferred instruction has opcode 8'hFF, the controller enters a HALT state: halted=1, no reads.
  - HALT is exited only by rst or by pc_load, which clears halted and goes to F_OP.
- Without the macro: 8'hFF is an ordinary opcode; no halted port, no HALT state.

Decomposition:
- Package fetch_pkg holds:
  - the state enum: IDLE, F_OP, F_A1, F_A2, F_DONE, HOLD, HALT;
  - INSTR_BYTES=3;
  - HALT_OPCODE=8'hFF;
  - RESET_PC default.
- Single module; no sub-module. The PC register is inline, since a separate pc_reg adds nothing beyond its load/increment mux.

Test Plan:
- Basic fetch: mem[0..2]=01,00,02; fetch_en=1, ex_ready=1 after reset.
  - ir_valid rises 4 cycles after F_OP with IR={01,00,02}.
  - pc=03 at transfer.
- Back-to-back: additionally mem[3..5]=01,01,02 and mem[6..8]=03,00,01.
  - Three instructions are delivered in order, 5 cycles apart.
  - pc=09 after the third.
- Backpressure: ex_ready=0 for 10 cycles after the first ir_valid.
  - IR holds {01,00,02}; ram_rd_en stays 0; pc stays 03.
  - With ex_ready=1: transfer, then F_OP at addr 03.
- Redirect mid-fetch: pc_load=1, pc_load_addr=06 during F_A1.
  - The partial fetch is aborted; next ram_addr=06.
  - Next IR={03,00,01}.
- Wrap and reset: pc_load_addr=FE with mem[FE]=0A, mem[FF]=0B, mem[00]=0C.
  - Required IR={0A,0B,0C}, pc=01.
  - Separately, rst asserted during F_A2: all outputs return to 0 asynchronously and pc=RESET_PC.
- (FETCH_HALT_EN) Halt: mem[3]=FF.
  - After that instruction transfers, halted=1 and no further reads.
  - pc_load to 00 resumes fetching at 00.
